// File: rtl/count_sequencer.sv
// Single-job count sequencer: accepts (term, mode) over valid/ready and counts
// 0..term once (one-shot) or repeatedly (periodic), with pause and abort.
module count_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_term,
  input  logic             cmd_mode,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] term, term_n;
  logic             mode, mode_n;
  logic [WIDTH-1:0] count_n;
  logic             tc_n;
  logic             done_n;
  logic             accept;
  logic             at_term;

  assign cmd_ready = ((state == IDLE) || (state == DONE)) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state == RUN) || (state == HOLD);
  assign at_term   = (count == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      term     <= '0;
      mode     <= 1'b0;
      tc_pulse <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      term     <= term_n;
      mode     <= mode_n;
      tc_pulse <= tc_n;
      done     <= done_n;
    end
  end

  // abort overrides every state; tc_pulse defaults low so it is a 1-cycle pulse
  always_comb begin
    state_n = state;
    count_n = count;
    term_n  = term;
    mode_n  = mode;
    tc_n    = 1'b0;
    done_n  = done;
    if (abort) begin
      state_n = IDLE;
      count_n = '0;
      done_n  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            term_n  = cmd_term;
            mode_n  = cmd_mode;
            count_n = '0;
            done_n  = 1'b0;
            state_n = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_n = HOLD;
          end else if (at_term) begin
            tc_n = 1'b1;
            if (mode) begin
              count_n = '0;
            end else begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end else begin
            count_n = count + WIDTH'(1);
          end
        end
        HOLD: begin
          if (!pause) state_n = RUN;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer; terminal-count events are checked by a
// scoreboard monitor against expectations queued when each job is started.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_term = '0;
  logic       cmd_mode = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic       busy;
  logic       tc_pulse;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int       at_edge;
    logic [3:0] cnt;
    logic     dn;
  } exp_t;
  exp_t q[$];

  count_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_term(cmd_term), .cmd_mode(cmd_mode), .pause(pause), .abort(abort),
    .count(count), .busy(busy), .tc_pulse(tc_pulse), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // Monitor: every tc_pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (tc_pulse) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL tc_unexpected cyc=%0d count=%0d required=no pulse", cyc, count);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cyc != e.at_edge || count !== e.cnt || done !== e.dn) begin
            errors++;
            $display("FAIL tc_event got edge=%0d count=%0d done=%0b required edge=%0d count=%0d done=%0b",
                     cyc, count, done, e.at_edge, e.cnt, e.dn);
          end
        end
      end else if (q.size() > 0 && q[0].at_edge <= cyc) begin
        checks++;
        errors++;
        $display("FAIL tc_missing cyc=%0d required pulse at edge=%0d", cyc, q[0].at_edge);
        void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_tc(input int at_edge, input logic [3:0] cnt, input logic dn);
    exp_t e;
    e.at_edge = at_edge;
    e.cnt     = cnt;
    e.dn      = dn;
    q.push_back(e);
  endtask

  // Presents a job for one edge; k is the accept edge
  task automatic start(input logic [3:0] t, input logic m, output int k);
    cmd_term  = t;
    cmd_mode  = m;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    k = cyc;
    chk("accept_busy", 32'(busy), 1);
    chk("accept_count", 32'(count), 0);
  endtask

  initial begin
    int k;
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_tc", 32'(tc_pulse), 0);
    step();
    rst = 1'b0;
    step();

    // asynchronous reset mid-run
    start(4'd10, 1'b0, k);
    step(); step(); step();
    chk("run_count3", 32'(count), 3);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_ready", 32'(cmd_ready), 1);
    step();
    rst = 1'b0;
    step();

    // one-shot term=5; later cmd_term changes must be ignored
    start(4'd5, 1'b0, k);
    expect_tc(k + 6, 4'd5, 1'b1);
    cmd_term = 4'd9;
    for (int i = 0; i < 6; i++) begin
      chk("os5_count", 32'(count), 32'(i));
      chk("os5_busy", 32'(busy), 1);
      step();
    end
    chk("os5_done", 32'(done), 1);
    chk("os5_busy_end", 32'(busy), 0);
    chk("os5_count_end", 32'(count), 5);
    pause = 1'b1;
    step();
    chk("done_pause_ready", 32'(cmd_ready), 1);
    chk("done_hold_count", 32'(count), 5);
    chk("done_hold_done", 32'(done), 1);
    pause = 1'b0;

    // one-shot term=4 with a 2-cycle pause at count=2
    start(4'd4, 1'b0, k);
    expect_tc(k + 8, 4'd4, 1'b1);
    step(); step();
    chk("pz_count_k2", 32'(count), 2);
    pause = 1'b1;
    step();
    chk("pz_count_k3", 32'(count), 2);
    chk("pz_busy_hold", 32'(busy), 1);
    step();
    chk("pz_count_k4", 32'(count), 2);
    pause = 1'b0;
    step();
    chk("pz_count_k5", 32'(count), 2);
    step();
    chk("pz_count_k6", 32'(count), 3);
    step();
    chk("pz_count_k7", 32'(count), 4);
    step();
    chk("pz_done", 32'(done), 1);

    // periodic term=3 over 12 cycles
    start(4'd3, 1'b1, k);
    expect_tc(k + 4, 4'd0, 1'b0);
    expect_tc(k + 8, 4'd0, 1'b0);
    expect_tc(k + 12, 4'd0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk("per3_count", 32'(count), 32'(i % 4));
      step();
    end
    chk("per3_count12", 32'(count), 0);

    // abort with cmd_valid in the same cycle, then accept once abort drops
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_term  = 4'd2;
    cmd_mode  = 1'b0;
    #1;
    chk("abort_ready", 32'(cmd_ready), 0);
    step();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_count", 32'(count), 0);
    chk("abort_done", 32'(done), 0);
    abort = 1'b0;
    #1;
    chk("post_abort_ready", 32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    k = cyc;
    chk("post_abort_busy", 32'(busy), 1);
    expect_tc(k + 3, 4'd2, 1'b1);
    step(); step(); step();
    chk("post_abort_done", 32'(done), 1);

    // abort in DONE blocks an accept
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_term  = 4'd1;
    step();
    chk("abort_done_busy", 32'(busy), 0);
    chk("abort_done_done", 32'(done), 0);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    step();
    chk("abort_done_idle", 32'(busy), 0);

    // boundaries: term=0 one-shot, then full-range periodic
    start(4'd0, 1'b0, k);
    expect_tc(k + 1, 4'd0, 1'b1);
    step();
    chk("t0_done", 32'(done), 1);
    chk("t0_busy", 32'(busy), 0);

    start(4'd15, 1'b1, k);
    expect_tc(k + 16, 4'd0, 1'b0);
    expect_tc(k + 32, 4'd0, 1'b0);
    for (int i = 0; i < 33; i++) begin
      chk("per15_count", 32'(count), 32'(i % 16));
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("per15_abort_count", 32'(count), 0);

    step(); step(); step();
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
